fpu_addsub_result_queue: RTL and testbench

- Registered result stage directly downstream of the combinational FP32 add/sub unit in the CPU-core FPU.
- Captures each add/sub result with its destination tag and exception flag, canonicalises overflow to ±Inf, classifies the result, and accumulates sticky status flags.
- Presents results to the register-file writeback port through a valid/ready FIFO, so the adder never stalls on a busy writeback port while the queue has space.

---
 rtl/fpu_pkg.sv | 22 ++
 rtl/fpu_result_classify.sv | 29 ++
 rtl/fpu_addsub_result_queue.sv | 160 ++++++++++++++++
 tb/tb_fpu_addsub_result_queue.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared FP32 field constants, sticky-flag indices and the classified-result
// record used by the add/sub result queue.
package fpu_pkg;

  localparam int SIGN_BIT = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam int MAN_W    = 23;
  localparam logic [7:0] EXP_MAX = 8'hFF;

  localparam int STICKY_EXC  = 0;
  localparam int STICKY_ZERO = 1;
  localparam int STICKY_OVF  = 2;

  typedef struct packed {
    logic [31:0] result;
    logic        exception;
    logic        zero;
    logic        ovf;
  } fp_class_t;

endpackage

// File: rtl/fpu_result_classify.sv
// Combinational canonicalise/classify of an add/sub result; overflow is
// rewritten to signed infinity, zero is flagged only without an exception.
module fpu_result_classify
  import fpu_pkg::*;
(
  input  logic [31:0] result,
  input  logic        exception,
  output fp_class_t   cls
);

  logic ovf_s;
  logic zero_s;

  assign ovf_s  = (result[EXP_MSB:EXP_LSB] == EXP_MAX) && !exception;
  assign zero_s = (result[EXP_MSB:0] == 31'd0) && !exception;

  // Build the classified record, dropping the mantissa on overflow.
  always_comb begin
    cls.exception = exception;
    cls.zero      = zero_s;
    cls.ovf       = ovf_s;
    if (ovf_s) begin
      cls.result = {result[SIGN_BIT], EXP_MAX, {MAN_W{1'b0}}};
    end else begin
      cls.result = result;
    end
  end

endmodule

// File: rtl/fpu_addsub_result_queue.sv
// Registered FIFO between the FP32 add/sub unit and register-file writeback.
// Optional same-cycle empty-queue bypass: FPU_RESULT_BYPASS_EN.
module fpu_addsub_result_queue
  import fpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_result,
  input  logic                       in_exception,
  input  logic [TAG_W-1:0]           in_tag,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_result,
  output logic [TAG_W-1:0]           out_tag,
  output logic                       out_exception,
  output logic                       out_zero,
  output logic                       out_ovf,
  output logic [2:0]                 sticky_flags,
  input  logic                       flags_clear,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [31:0]      result;
    logic [TAG_W-1:0] tag;
    logic             exception;
    logic             zero;
    logic             ovf;
  } entry_t;

  entry_t           mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic [2:0]       sticky_r;

  fp_class_t in_cls_s;
  entry_t    head_s;
  logic      full_s;
  logic      empty_s;
  logic      push_s;
  logic      pop_s;
  logic      bypass_s;
  logic      flag_upd_s;

  fpu_result_classify u_classify (
    .result    (in_result),
    .exception (in_exception),
    .cls       (in_cls_s)
  );

  assign full_s       = (count_r == CNT_W'(DEPTH));
  assign empty_s      = (count_r == {CNT_W{1'b0}});
  assign in_ready     = !full_s;
  assign count        = count_r;
  assign sticky_flags = sticky_r;
  assign head_s       = mem_r[rd_ptr_r];

  // Handshake decode; a bypassed result is consumed without touching storage.
  always_comb begin
    bypass_s = 1'b0;
`ifdef FPU_RESULT_BYPASS_EN
    bypass_s = empty_s && in_valid && out_ready;
`endif
    push_s     = in_valid && !full_s && !bypass_s;
    pop_s      = !empty_s && out_ready;
    flag_upd_s = push_s || bypass_s;
  end

  // Output view: head slot when occupied, otherwise zeros (or the bypassed input).
  always_comb begin
    out_valid     = 1'b0;
    out_result    = 32'd0;
    out_tag       = {TAG_W{1'b0}};
    out_exception = 1'b0;
    out_zero      = 1'b0;
    out_ovf       = 1'b0;
    if (!empty_s) begin
      out_valid     = 1'b1;
      out_result    = head_s.result;
      out_tag       = head_s.tag;
      out_exception = head_s.exception;
      out_zero      = head_s.zero;
      out_ovf       = head_s.ovf;
    end
`ifdef FPU_RESULT_BYPASS_EN
    else if (in_valid) begin
      out_valid     = 1'b1;
      out_result    = in_cls_s.result;
      out_tag       = in_tag;
      out_exception = in_cls_s.exception;
      out_zero      = in_cls_s.zero;
      out_ovf       = in_cls_s.ovf;
    end
`endif
    else begin
      out_valid = 1'b0;
    end
  end

  // Storage and pointers; both pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {$bits(entry_t){1'b0}};
      end
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= '{result:    in_cls_s.result,
                             tag:       in_tag,
                             exception: in_cls_s.exception,
                             zero:      in_cls_s.zero,
                             ovf:       in_cls_s.ovf};
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
    end
  end

  // Occupancy; a simultaneous push and pop leaves it unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {CNT_W{1'b0}};
    end else begin
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Sticky status; clear wins over a same-cycle push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_r <= 3'b000;
    end else if (flags_clear) begin
      sticky_r <= 3'b000;
    end else if (flag_upd_s) begin
      sticky_r[STICKY_OVF]  <= sticky_r[STICKY_OVF]  | in_cls_s.ovf;
      sticky_r[STICKY_ZERO] <= sticky_r[STICKY_ZERO] | in_cls_s.zero;
      sticky_r[STICKY_EXC]  <= sticky_r[STICKY_EXC]  | in_cls_s.exception;
    end else begin
      sticky_r <= sticky_r;
    end
  end

endmodule

// File: tb/tb_fpu_addsub_result_queue.sv
// Directed bench for fpu_addsub_result_queue: a queue-based reference model
// checked every cycle, plus hand-computed literal expectations.
module tb_fpu_addsub_result_queue;

  localparam int DEPTH = 4;
  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_result = 32'd0;
  logic             in_exception = 1'b0;
  logic [TAG_W-1:0] in_tag = 5'd0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      out_result;
  logic [TAG_W-1:0] out_tag;
  logic             out_exception;
  logic             out_zero;
  logic             out_ovf;
  logic [2:0]       sticky_flags;
  logic             flags_clear = 1'b0;
  logic [2:0]       count;

  int tests = 0;
  int fails = 0;

  fpu_addsub_result_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .in_exception(in_exception), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_tag(out_tag), .out_exception(out_exception), .out_zero(out_zero),
    .out_ovf(out_ovf), .sticky_flags(sticky_flags), .flags_clear(flags_clear),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] result;
    logic [4:0]  tag;
    logic        exc;
    logic        zero;
    logic        ovf;
  } m_entry_t;

  m_entry_t   mq[$];
  logic [2:0] m_sticky = 3'b000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour straight from the IEEE field rules.
  function automatic m_entry_t canon(input logic [31:0] r, input logic e, input logic [4:0] t);
    m_entry_t x;
    x.exc    = e;
    x.ovf    = !e && (r[30:23] == 8'd255);
    x.zero   = !e && ((r << 1) == 32'd0);
    x.result = x.ovf ? (r & 32'hFF80_0000) : r;
    x.tag    = t;
    return x;
  endfunction

  // Model state advance on the same edge as the DUT.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_sticky = 3'b000;
    end else begin
      int sz;
      bit bp;
      bit pu;
      m_entry_t e;
      sz = mq.size();
      bp = 1'b0;
`ifdef FPU_RESULT_BYPASS_EN
      bp = (sz == 0) && in_valid && out_ready;
`endif
      e  = canon(in_result, in_exception, in_tag);
      pu = in_valid && (sz < DEPTH) && !bp;
      if (sz > 0 && out_ready) void'(mq.pop_front());
      if (pu) mq.push_back(e);
      if (flags_clear) m_sticky = 3'b000;
      else if (pu || bp) m_sticky = m_sticky | {e.ovf, e.zero, e.exc};
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    m_entry_t h;
    logic     v;
    v = (mq.size() > 0);
    h = '{result: 32'd0, tag: 5'd0, exc: 1'b0, zero: 1'b0, ovf: 1'b0};
    if (v) h = mq[0];
`ifdef FPU_RESULT_BYPASS_EN
    else if (in_valid && rst_n) begin
      v = 1'b1;
      h = canon(in_result, in_exception, in_tag);
    end
`endif
    chk("m_count", 32'(count), 32'(mq.size()));
    chk("m_in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
    chk("m_sticky", 32'(sticky_flags), 32'(m_sticky));
    chk("m_out_valid", 32'(out_valid), 32'(v));
    chk("m_out_result", out_result, h.result);
    chk("m_out_tag", 32'(out_tag), 32'(h.tag));
    chk("m_out_exc", 32'(out_exception), 32'(h.exc));
    chk("m_out_zero", 32'(out_zero), 32'(h.zero));
    chk("m_out_ovf", 32'(out_ovf), 32'(h.ovf));
  end

  task automatic drive(input logic v, input logic [31:0] r, input logic e,
                       input logic [4:0] t, input logic rdy, input logic clr);
    in_valid = v; in_result = r; in_exception = e; in_tag = t;
    out_ready = rdy; flags_clear = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sticky", 32'(sticky_flags), 32'd0);
    rst_n = 1'b1;
    drive(1'b0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b0);

    // Plain 1.5 push, one-cycle latency
    drive(1'b1, 32'h3FC0_0000, 1'b0, 5'd3, 1'b0, 1'b0);
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_result", out_result, 32'h3FC0_0000);
    chk("t1_tag", 32'(out_tag), 32'd3);
    chk("t1_zero", 32'(out_zero), 32'd0);
    chk("t1_ovf", 32'(out_ovf), 32'd0);
    chk("t1_count", 32'(count), 32'd1);
    drive(1'b0, 32'd0, 1'b0, 5'd0, 1'b1, 1'b0);

    // Overflow canonicalised to +Inf
    drive(1'b1, 32'h7F80_1234, 1'b0, 5'd4, 1'b0, 1'b0);
    chk("t2_result", out_result, 32'h7F80_0000);
    chk("t2_ovf", 32'(out_ovf), 32'd1);
    chk("t2_sticky", 32'(sticky_flags), 32'b100);
    drive(1'b0, 32'd0, 1'b0, 5'd0, 1'b1, 1'b0);

    // Exception vs -0
    drive(1'b0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b1);
    chk("t3_cleared", 32'(sticky_flags), 32'd0);
    drive(1'b1, 32'h0000_0000, 1'b1, 5'd5, 1'b0, 1'b0);
    drive(1'b1, 32'h8000_0000, 1'b0, 5'd6, 1'b0, 1'b0);
    chk("t3_exc", 32'(out_exception), 32'd1);
    chk("t3_zero0", 32'(out_zero), 32'd0);
    chk("t3_sticky", 32'(sticky_flags), 32'b011);
    drive(1'b0, 32'd0, 1'b0, 5'd0, 1'b1, 1'b0);
    chk("t3_zero1", 32'(out_zero), 32'd1);
    chk("t3_tag1", 32'(out_tag), 32'd6);
    drive(1'b0, 32'd0, 1'b0, 5'd0, 1'b1, 1'b0);

    // Fill, overfill, drain in order
    for (int i = 0; i < DEPTH; i++) drive(1'b1, 32'h4000_0000 + 32'(i), 1'b0, 5'(i), 1'b0, 1'b0);
    chk("t4_in_ready", 32'(in_ready), 32'd0);
    chk("t4_count", 32'(count), 32'd4);
    drive(1'b1, 32'h4100_0000, 1'b0, 5'd9, 1'b0, 1'b0);
    chk("t4_ignored", 32'(count), 32'd4);
    for (int i = 0; i < DEPTH; i++) begin
      chk("t4_drain_tag", 32'(out_tag), 32'(i));
      drive(1'b0, 32'd0, 1'b0, 5'd0, 1'b1, 1'b0);
    end
    chk("t4_empty", 32'(count), 32'd0);

    // Streaming at count=2 across pointer wrap
    drive(1'b1, 32'h3F80_0000, 1'b0, 5'd10, 1'b0, 1'b0);
    drive(1'b1, 32'h3F80_0001, 1'b0, 5'd11, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'h3F90_0000 + 32'(i), 1'b0, 5'(12 + i), 1'b1, 1'b0);
      chk("t5_count", 32'(count), 32'd2);
      chk("t5_head_tag", 32'(out_tag), 32'(11 + i));
    end
    drive(1'b0, 32'd0, 1'b0, 5'd0, 1'b1, 1'b0);
    drive(1'b0, 32'd0, 1'b0, 5'd0, 1'b1, 1'b0);

    // Clear priority over an overflow push, then reset with 3 queued
    drive(1'b1, 32'hFF80_0005, 1'b0, 5'd1, 1'b0, 1'b1);
    chk("t6_sticky", 32'(sticky_flags), 32'd0);
    chk("t6_result", out_result, 32'hFF80_0000);
    drive(1'b1, 32'h4040_0000, 1'b0, 5'd2, 1'b0, 1'b0);
    drive(1'b1, 32'h4080_0000, 1'b0, 5'd3, 1'b0, 1'b0);
    chk("t6_count3", 32'(count), 32'd3);
    in_valid = 1'b0; out_ready = 1'b0; flags_clear = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(out_valid), 32'd0);
    chk("t6_rst_count", 32'(count), 32'd0);
    chk("t6_rst_sticky", 32'(sticky_flags), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Empty queue with a ready consumer
    in_valid = 1'b1; in_result = 32'h4000_0000; in_exception = 1'b0;
    in_tag = 5'd7; out_ready = 1'b1;
    #1;
`ifdef FPU_RESULT_BYPASS_EN
    chk("t7_bp_valid", 32'(out_valid), 32'd1);
    chk("t7_bp_result", out_result, 32'h4000_0000);
`else
    chk("t7_nobp_valid", 32'(out_valid), 32'd0);
`endif
    @(posedge clk);
    #1;
`ifdef FPU_RESULT_BYPASS_EN
    chk("t7_count", 32'(count), 32'd0);
`else
    chk("t7_count", 32'(count), 32'd1);
    chk("t7_result", out_result, 32'h4000_0000);
`endif
    drive(1'b0, 32'd0, 1'b0, 5'd0, 1'b1, 1'b0);
    drive(1'b0, 32'd0, 1'b0, 5'd0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
